weighted_rr_arbiter: RTL and testbench

//  N-requester round-robin arbiter with per-requester burst weights and grant/ready handshake.
//  The current owner keeps the grant for up to weight+1 accepted transfers, then priority rotates past it.

---
 rtl/wrr_arb_pkg.sv | 22 ++
 rtl/wrr_rr_picker.sv | 22 ++
 rtl/weighted_rr_arbiter.sv | 88 ++++++++
 tb/tb_weighted_rr_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wrr_arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
// Holds the default weight width and small index helpers.
package wrr_arb_pkg;

    localparam int DEFAULT_WW = 4;

    // Modulo-n increment of a requester index.
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

    // Index of the set bit in a one-hot vector; 0 when no bit is set.
    function automatic int onehot_to_idx(input logic [63:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/wrr_rr_picker.sv
// Combinational rotating picker: returns the one-hot first set request
// found when scanning ptr, ptr+1, ... wrapping modulo N.
module wrr_rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  requests,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] rot_req;
    logic [N-1:0] rot_gnt;

    // Rotate requests so ptr lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot_req = N'({requests, requests} >> ptr);
        rot_gnt = rot_req & (~rot_req + N'(1));
        grant   = N'({rot_gnt, rot_gnt} >> (N - int'(ptr)));
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with grant/ready handshake.
// The owner of a burst keeps the grant for weight+1 accepted transfers,
// after which priority rotates past it.
// Optional build macro WRR_ARB_LOCK_EN adds a lock input that freezes the
// burst counter while asserted.
module weighted_rr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int WW = DEFAULT_WW,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  requests,
    input  logic [N*WW-1:0] weights,
    input  logic          grant_ready,
`ifdef WRR_ARB_LOCK_EN
    input  logic          lock,
`endif
    output logic [N-1:0]  grants,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic          burst_active;
    logic [WW-1:0] rem;

    logic [N-1:0]  scan_gnt;
    logic          hold_owner;
    logic          accept;
    logic          lock_in;
    logic [WW-1:0] sel_weight;

`ifdef WRR_ARB_LOCK_EN
    assign lock_in = lock;
`else
    assign lock_in = 1'b0;
`endif

    wrr_rr_picker #(.N(N), .IW(IW)) u_picker (
        .requests (requests),
        .ptr      (ptr),
        .grant    (scan_gnt)
    );

    // Grant selection: the burst owner wins while it still requests, else the rotating scan.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        hold_owner  = burst_active & requests[owner];
        grants      = hold_owner ? (N'(1) << owner) : scan_gnt;
        grant_valid = |grants;
        grant_idx   = IW'(onehot_to_idx(64'(grants)));
        accept      = grant_valid & grant_ready;
        sel_weight  = weights[grant_idx*WW +: WW];
    end

    // Burst and pointer state advance on accepted transfers, or drop on abort.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (rst) begin
            ptr          <= '0;
            owner        <= '0;
            burst_active <= 1'b0;
            rem          <= '0;
        end else if (accept) begin
            if (hold_owner) begin
                // Continuing burst; a lock freezes the remaining count.
                if (!lock_in) begin
                    rem          <= (rem == '0) ? '0 : rem - WW'(1);
                    burst_active <= (rem > WW'(1));
                end
            end else begin
                // New burst from the scan winner.
                owner        <= grant_idx;
                ptr          <= IW'(next_idx(int'(grant_idx), N));
                rem          <= sel_weight;
                burst_active <= (sel_weight != '0) | lock_in;
            end
        end else if (burst_active && !requests[owner]) begin
            // Owner dropped its request: abort; ptr already points past it.
            burst_active <= 1'b0;
        end
    end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed, table-driven bench for weighted_rr_arbiter (N=2 and N=4 instances).
module tb_weighted_rr_arbiter;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       lck;
        logic [3:0] exp_gnt;
        int         exp_idx;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req2;
    logic [7:0]  weights2;
    logic [3:0]  req4;
    logic [15:0] weights4;
    logic        ready;
    logic        lock;

    logic [1:0]  grants2;
    logic        valid2;
    logic        idx2;
    logic [3:0]  grants4;
    logic        valid4;
    logic [1:0]  idx4;

    int total = 0;
    int bad   = 0;

    vec_t tbl[16];
    int   n_tbl;

    weighted_rr_arbiter #(.N(2), .WW(4)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .requests    (req2),
        .weights     (weights2),
        .grant_ready (ready),
`ifdef WRR_ARB_LOCK_EN
        .lock        (lock),
`endif
        .grants      (grants2),
        .grant_valid (valid2),
        .grant_idx   (idx2)
    );

    weighted_rr_arbiter #(.N(4), .WW(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .requests    (req4),
        .weights     (weights4),
        .grant_ready (ready),
`ifdef WRR_ARB_LOCK_EN
        .lock        (lock),
`endif
        .grants      (grants4),
        .grant_valid (valid4),
        .grant_idx   (idx4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Synchronous-looking reset pulse; leaves inputs changing at posedge+2.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic add(input logic [3:0] r, input logic rd, input logic lk,
                       input logic [3:0] g, input int idx);
        tbl[n_tbl] = '{req: r, rdy: rd, lck: lk, exp_gnt: g, exp_idx: idx};
        n_tbl++;
    endtask

    // Apply each table row for one cycle and compare the combinational outputs.
    task automatic run_table(input string name, input bit two);
        for (int i = 0; i < n_tbl; i++) begin
            ready = tbl[i].rdy;
            lock  = tbl[i].lck;
            if (two) req2 = tbl[i].req[1:0];
            else     req4 = tbl[i].req;
            #1;
            if (two) begin
                check($sformatf("%s[%0d].grants", name, i), int'(grants2), int'(tbl[i].exp_gnt[1:0]));
                check($sformatf("%s[%0d].valid", name, i), int'(valid2), int'(tbl[i].exp_gnt[1:0] != 2'b00));
                check($sformatf("%s[%0d].idx", name, i), int'(idx2), tbl[i].exp_idx);
            end else begin
                check($sformatf("%s[%0d].grants", name, i), int'(grants4), int'(tbl[i].exp_gnt));
                check($sformatf("%s[%0d].valid", name, i), int'(valid4), int'(tbl[i].exp_gnt != 4'b0000));
                check($sformatf("%s[%0d].idx", name, i), int'(idx4), tbl[i].exp_idx);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; req2 = '0; req4 = '0; weights2 = '0; weights4 = '0;
        ready = 1'b1; lock = 1'b0;
        #12;
        // Reset state with no requests
        check("reset.grants4", int'(grants4), 0);
        check("reset.valid4", int'(valid4), 0);
        check("reset.idx4", int'(idx4), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: N=2 plain round-robin
        do_reset();
        n_tbl = 0;
        add(4'b01, 1, 0, 4'b01, 0); add(4'b00, 1, 0, 4'b00, 0);
        add(4'b10, 1, 0, 4'b10, 1); add(4'b11, 1, 0, 4'b01, 0);
        add(4'b11, 1, 0, 4'b10, 1); add(4'b00, 1, 0, 4'b00, 0);
        add(4'b11, 1, 0, 4'b01, 0); add(4'b00, 1, 0, 4'b00, 0);
        add(4'b11, 1, 0, 4'b10, 1); add(4'b11, 1, 0, 4'b01, 0);
        run_table("t1", 1'b1);
        req2 = '0;

        // Test 2: N=4 weighted bursts w0=0 w1=2 w2=0 w3=1
        weights4 = 16'h1020;
        do_reset();
        n_tbl = 0;
        add(4'hF, 1, 0, 4'b0001, 0); add(4'hF, 1, 0, 4'b0010, 1);
        add(4'hF, 1, 0, 4'b0010, 1); add(4'hF, 1, 0, 4'b0010, 1);
        add(4'hF, 1, 0, 4'b0100, 2); add(4'hF, 1, 0, 4'b1000, 3);
        add(4'hF, 1, 0, 4'b1000, 3); add(4'hF, 1, 0, 4'b0001, 0);
        add(4'hF, 1, 0, 4'b0010, 1); add(4'hF, 1, 0, 4'b0010, 1);
        run_table("t2", 1'b0);

        // Test 3: back-pressure holds state
        weights4 = 16'h0000;
        do_reset();
        n_tbl = 0;
        add(4'hF, 0, 0, 4'b0001, 0); add(4'hF, 0, 0, 4'b0001, 0);
        add(4'hF, 0, 0, 4'b0001, 0); add(4'hF, 1, 0, 4'b0001, 0);
        add(4'hF, 1, 0, 4'b0010, 1); add(4'hF, 1, 0, 4'b0100, 2);
        add(4'hF, 1, 0, 4'b1000, 3);
        run_table("t3", 1'b0);

        // Test 4: owner drops its request mid-burst
        weights4 = 16'h0030;
        do_reset();
        n_tbl = 0;
        add(4'b0010, 1, 0, 4'b0010, 1); add(4'b0101, 1, 0, 4'b0100, 2);
        add(4'b0101, 1, 0, 4'b0001, 0);
        run_table("t4", 1'b0);

        // Test 5: asynchronous reset mid-burst (owner=1, rem=2)
        weights4 = 16'h0020;
        do_reset();
        req4 = 4'hF; ready = 1'b1;
        #1;
        check("t5.first", int'(idx4), 0);
        @(posedge clk); #1;
        check("t5.burst_start", int'(grants4), 4'b0010);
        @(posedge clk); #1;
        check("t5.burst_cont", int'(grants4), 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("t5.in_reset", int'(grants4), 4'b0001);
        @(posedge clk); #1;
        check("t5.reset_edge", int'(grants4), 4'b0001);
        rst = 1'b0;
        #1;
        check("t5.after_reset", int'(grants4), 4'b0001);
        check("t5.after_idx", int'(idx4), 0);
        @(posedge clk); #1;
        check("t5.ptr_from0", int'(idx4), 1);

`ifdef WRR_ARB_LOCK_EN
        // Test 6: lock extends a weight-0 burst
        weights4 = 16'h0000;
        req4 = '0;
        do_reset();
        n_tbl = 0;
        add(4'hF, 1, 1, 4'b0001, 0); add(4'hF, 1, 1, 4'b0001, 0);
        add(4'hF, 1, 1, 4'b0001, 0); add(4'hF, 1, 1, 4'b0001, 0);
        add(4'hF, 1, 0, 4'b0001, 0); add(4'hF, 1, 0, 4'b0010, 1);
        run_table("t6", 1'b0);
        lock = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
